// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: cp0 ExcCodes, FSM state encoding,
// bit positions inside the mem_exc flag vector, and the priority-encoder result record.
// No ports; imported by exc_prio_enc and exc_ctrl.
package exc_ctrl_pkg;

  // cp0 Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // mem_exc = {adel_if, ri, sys, bp, ov, adel_d, ades}
  localparam int EXB_ADEL_IF = 6;
  localparam int EXB_RI      = 5;
  localparam int EXB_SYS     = 4;
  localparam int EXB_BP      = 3;
  localparam int EXB_OV      = 2;
  localparam int EXB_ADEL_D  = 1;
  localparam int EXB_ADES    = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_REDIR  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic       hit;        // some event is pending
    logic [4:0] excode;     // winning ExcCode (don't care for eret)
    logic       is_eret;    // eret won (no exception/interrupt alongside)
    logic       is_if_addr; // fetch-address error won: BadVAddr comes from the PC
  } prio_t;

  // EPC points at the branch when the faulting instruction sits in a delay slot.
  // Wraps modulo 2^32 on purpose.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Purpose: combinational priority pick among interrupt, MEM-stage exception flags and eret.
// Latency: 0 cycles (pure combinational). Backpressure: none, no storage.
// Ports: int_req, mem_exc[6:0], mem_eret in; res (prio_t: hit/excode/is_eret/is_if_addr) out.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_req,
  input  logic [6:0] mem_exc,
  input  logic       mem_eret,
  output prio_t      res
);

  always_comb begin
    res            = '0;
    res.hit        = int_req | (|mem_exc) | mem_eret;
    if (int_req) begin
      res.excode = EXC_INT;
    end else if (mem_exc[EXB_ADEL_IF]) begin
      res.excode     = EXC_ADEL;
      res.is_if_addr = 1'b1;
    end else if (mem_exc[EXB_RI]) begin
      res.excode = EXC_RI;
    end else if (mem_exc[EXB_SYS]) begin
      res.excode = EXC_SYS;
    end else if (mem_exc[EXB_BP]) begin
      res.excode = EXC_BP;
    end else if (mem_exc[EXB_OV]) begin
      res.excode = EXC_OV;
    end else if (mem_exc[EXB_ADEL_D]) begin
      res.excode = EXC_ADEL;
    end else if (mem_exc[EXB_ADES]) begin
      res.excode = EXC_ADES;
    end else if (mem_eret) begin
      // eret only reaches here when nothing else is pending
      res.is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Purpose: exception/interrupt sequencer in front of cp0: picks the winning MEM-stage event,
//   commits it to cp0 for one cycle, flushes the pipe and hands the new PC to fetch.
// Latency: event sampled in T; exc_valid/flush in T+1; redirect_valid from T+2.
// Backpressure: redirect_valid/redirect_pc held until redirect_ready; flush then stays HOLD_CYCLES.
// Ports: clk, reset (async, active-high); mem_* MEM-stage instruction info; int_req, cp0_bev,
//   cp0_epc from cp0; exc_* commit port to cp0; flush to IF..MEM; redirect_valid/_pc/_ready to fetch.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BEV1    = 32'hBFC0_0380,
  parameter logic [31:0] VEC_BEV0    = 32'h8000_0180,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [6:0]  mem_exc,
  input  logic [31:0] mem_addr,
  input  logic        mem_eret,
  input  logic        int_req,
  input  logic        cp0_bev,
  input  logic [31:0] cp0_epc,
  output logic        exc_valid,
  output logic [4:0]  exc_excode,
  output logic        exc_bd,
  output logic [31:0] exc_epc,
  output logic [31:0] exc_badvaddr,
  output logic        exc_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  prio_t           prio;
  logic            take;
  logic            load;
  logic            exc_valid_n, exc_eret_n, flush_n, redirect_valid_n;

  exc_prio_enc u_prio (
    .int_req  (int_req),
    .mem_exc  (mem_exc),
    .mem_eret (mem_eret),
    .res      (prio)
  );

  assign take = mem_valid & prio.hit;

  // Next state plus next values of the strobes; strobes are registered so every
  // output comes straight from a flop.
  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    load             = 1'b0;
    exc_eret_n       = 1'b0;
    case (state)
      S_IDLE: begin
        // Events arriving in any other state belong to instructions being flushed.
        if (take) begin
          state_n    = S_COMMIT;
          load       = 1'b1;
          exc_eret_n = prio.is_eret;
        end
      end
      S_COMMIT: state_n = S_REDIR;
      S_REDIR: begin
        if (redirect_ready) begin
          state_n = S_HOLD;
          cnt_n   = CW'(HOLD_CYCLES);
        end
      end
      S_HOLD: begin
        if (cnt <= CW'(1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    exc_valid_n      = (state_n == S_COMMIT);
    flush_n          = (state_n != S_IDLE);
    redirect_valid_n = (state_n == S_REDIR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      exc_valid      <= 1'b0;
      exc_eret       <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      exc_valid      <= exc_valid_n;
      exc_eret       <= exc_eret_n;
      flush          <= flush_n;
      redirect_valid <= redirect_valid_n;
    end
  end

  // Commit payload and redirect target are captured in the take cycle and held
  // stable through COMMIT/REDIRECT, independent of later cp0_epc/cp0_bev changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_excode   <= '0;
      exc_bd       <= 1'b0;
      exc_epc      <= '0;
      exc_badvaddr <= '0;
      redirect_pc  <= '0;
    end else if (load) begin
      exc_excode   <= prio.excode;
      exc_bd       <= mem_bd;
      exc_epc      <= epc_of(mem_pc, mem_bd);
      exc_badvaddr <= prio.is_if_addr ? mem_pc : mem_addr;
      redirect_pc  <= prio.is_eret ? cp0_epc : (cp0_bev ? VEC_BEV1 : VEC_BEV0);
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl: reset, priority, EPC/BD, eret targets,
// redirect backpressure, hold length, and asynchronous reset abort.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic [31:0] mem_addr;
  logic        mem_eret;
  logic        int_req;
  logic        cp0_bev;
  logic [31:0] cp0_epc;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_bd         (mem_bd),
    .mem_exc        (mem_exc),
    .mem_addr       (mem_addr),
    .mem_eret       (mem_eret),
    .int_req        (int_req),
    .cp0_bev        (cp0_bev),
    .cp0_epc        (cp0_epc),
    .exc_valid      (exc_valid),
    .exc_excode     (exc_excode),
    .exc_bd         (exc_bd),
    .exc_epc        (exc_epc),
    .exc_badvaddr   (exc_badvaddr),
    .exc_eret       (exc_eret),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  task automatic clear_inputs();
    mem_valid      = 1'b0;
    mem_pc         = '0;
    mem_bd         = 1'b0;
    mem_exc        = '0;
    mem_addr       = '0;
    mem_eret       = 1'b0;
    int_req        = 1'b0;
    cp0_bev        = 1'b0;
    cp0_epc        = '0;
    redirect_ready = 1'b1;
  endtask

  // Present one event for one cycle; returns at the negedge of the COMMIT cycle (T+1).
  task automatic fire(input logic [6:0] ex, input logic ir, input logic er, input logic [31:0] pc,
                      input logic [31:0] addr, input logic bd, input logic bev, input logic [31:0] epc);
    @(negedge clk);
    mem_exc   = ex;
    int_req   = ir;
    mem_eret  = er;
    mem_pc    = pc;
    mem_addr  = addr;
    mem_bd    = bd;
    cp0_bev   = bev;
    cp0_epc   = epc;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_exc   = '0;
    int_req   = 1'b0;
    mem_eret  = 1'b0;
  endtask

  // Accept any pending redirect and wait (bounded) for the sequence to return to idle.
  task automatic drain();
    redirect_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (flush === 1'b0) break;
    end
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: flush=%b required 0", flush);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({exc_valid, exc_eret, flush, redirect_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 0000", {exc_valid, exc_eret, flush, redirect_valid});
    end
    checks++;
    if ({exc_excode, exc_bd, exc_epc, exc_badvaddr, redirect_pc} !== '0) begin
      errors++;
      $display("FAIL reset_data: excode=%h epc=%h badv=%h rpc=%h required 0", exc_excode, exc_epc, exc_badvaddr, redirect_pc);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (flush !== 1'b0 || exc_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: flush=%b exc_valid=%b required 0 0", flush, exc_valid);
    end
  endtask

  task automatic test_no_take();
    @(negedge clk);
    mem_valid = 1'b0;
    mem_exc   = 7'b0100000;
    int_req   = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (exc_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL bubble_ignored: exc_valid=%b flush=%b required 0 0", exc_valid, flush);
    end
    mem_exc = '0;
    int_req = 1'b0;
  endtask

  task automatic test_ri();
    int fl;
    fire(7'b0100000, 1'b0, 1'b0, 32'hBFC0_0100, 32'h0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (exc_valid !== 1'b1 || exc_excode !== 5'h0a || exc_epc !== 32'hBFC0_0100 || exc_bd !== 1'b0) begin
      errors++;
      $display("FAIL ri_commit: valid=%b code=%h epc=%h bd=%b required 1 0a bfc00100 0", exc_valid, exc_excode, exc_epc, exc_bd);
    end
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0 || exc_eret !== 1'b0) begin
      errors++;
      $display("FAIL ri_commit_ctl: flush=%b rv=%b eret=%b required 1 0 0", flush, redirect_valid, exc_eret);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380 || exc_valid !== 1'b0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL ri_redirect: rv=%b rpc=%h ev=%b flush=%b required 1 bfc00380 0 1", redirect_valid, redirect_pc, exc_valid, flush);
    end
    fl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (flush === 1'b1) fl++;
      else break;
    end
    checks++;
    if (fl != 2) begin
      errors++;
      $display("FAIL ri_hold_len: flush cycles after accept=%0d required 2", fl);
    end
  endtask

  task automatic test_ov_bd();
    fire(7'b0000100, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (exc_excode !== 5'h0c || exc_epc !== 32'h8000_0004 || exc_bd !== 1'b1) begin
      errors++;
      $display("FAIL ov_bd: code=%h epc=%h bd=%b required 0c 80000004 1", exc_excode, exc_epc, exc_bd);
    end
    @(negedge clk);
    checks++;
    if (redirect_pc !== 32'h8000_0180 || redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL ov_target: rpc=%h rv=%b required 80000180 1", redirect_pc, redirect_valid);
    end
    drain();
    // delay-slot EPC wraps below zero
    fire(7'b0000001, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1233, 1'b1, 1'b0, 32'h0);
    checks++;
    if (exc_epc !== 32'hFFFF_FFFC || exc_excode !== 5'h05 || exc_badvaddr !== 32'h0000_1233) begin
      errors++;
      $display("FAIL epc_wrap: epc=%h code=%h badv=%h required fffffffc 05 00001233", exc_epc, exc_excode, exc_badvaddr);
    end
    drain();
  endtask

  task automatic test_int_priority();
    int pulses;
    @(negedge clk);
    int_req   = 1'b1;
    mem_exc   = 7'b0000001;
    mem_valid = 1'b1;
    mem_pc    = 32'h8000_1000;
    mem_addr  = 32'h0000_2000;
    cp0_bev   = 1'b1;
    pulses    = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (exc_valid === 1'b1) pulses++;
      if (i == 1) begin
        checks++;
        if (exc_excode !== 5'h00 || exc_eret !== 1'b0 || exc_badvaddr !== 32'h0000_2000) begin
          errors++;
          $display("FAIL int_code: code=%h eret=%b badv=%h required 00 0 00002000", exc_excode, exc_eret, exc_badvaddr);
        end
      end
      if (i == 4) begin
        mem_valid = 1'b0;
        int_req   = 1'b0;
        mem_exc   = '0;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL int_single_pulse: pulses=%0d required 1", pulses);
    end
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL int_back_idle: flush=%b required 0", flush);
    end
  endtask

  task automatic test_eret();
    fire(7'b0, 1'b0, 1'b1, 32'h8000_0040, 32'h0, 1'b0, 1'b1, 32'hBFC0_0200);
    cp0_epc = 32'h1111_1111;  // later EPC change must not affect the target
    checks++;
    if (exc_valid !== 1'b1 || exc_eret !== 1'b1) begin
      errors++;
      $display("FAIL eret_commit: valid=%b eret=%b required 1 1", exc_valid, exc_eret);
    end
    @(negedge clk);
    checks++;
    if (redirect_pc !== 32'hBFC0_0200 || exc_eret !== 1'b0) begin
      errors++;
      $display("FAIL eret_target: rpc=%h eret=%b required bfc00200 0", redirect_pc, exc_eret);
    end
    drain();
    fire(7'b0010000, 1'b0, 1'b1, 32'h8000_0040, 32'h0, 1'b0, 1'b1, 32'hBFC0_0200);
    checks++;
    if (exc_eret !== 1'b0 || exc_excode !== 5'h08 || exc_valid !== 1'b1) begin
      errors++;
      $display("FAIL eret_sys: eret=%b code=%h valid=%b required 0 08 1", exc_eret, exc_excode, exc_valid);
    end
    @(negedge clk);
    checks++;
    if (redirect_pc !== 32'hBFC0_0380) begin
      errors++;
      $display("FAIL eret_sys_target: rpc=%h required bfc00380", redirect_pc);
    end
    drain();
  endtask

  task automatic test_prio_table();
    logic [6:0]  tv   [0:6];
    logic [4:0]  code [0:6];
    logic [31:0] badv [0:6];
    tv   = '{7'b1111111, 7'b0111111, 7'b0011111, 7'b0001111, 7'b0000111, 7'b0000011, 7'b0000001};
    code = '{5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05};
    badv = '{32'h0040_1000, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
             32'h1234_5678, 32'h1234_5678};
    for (int i = 0; i < 7; i++) begin
      fire(tv[i], 1'b0, 1'b0, 32'h0040_1000, 32'h1234_5678, 1'b0, 1'b1, 32'h0);
      checks++;
      if (exc_valid !== 1'b1 || exc_excode !== code[i] || exc_badvaddr !== badv[i]) begin
        errors++;
        $display("FAIL prio_%0d: valid=%b code=%h badv=%h required 1 %h %h", i, exc_valid, exc_excode, exc_badvaddr, code[i], badv[i]);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int fl;
    redirect_ready = 1'b0;
    fire(7'b0010000, 1'b0, 1'b0, 32'h8000_2000, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180 || flush !== 1'b1 || exc_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_%0d: rv=%b rpc=%h flush=%b ev=%b required 1 80000180 1 0", i, redirect_valid, redirect_pc, flush, exc_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_still_valid: rv=%b required 1", redirect_valid);
    end
    redirect_ready = 1'b1;
    fl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (flush === 1'b1) fl++;
      else break;
    end
    checks++;
    if (fl != 2) begin
      errors++;
      $display("FAIL bp_hold_len: flush cycles after accept=%0d required 2", fl);
    end
  endtask

  task automatic test_async_reset();
    redirect_ready = 1'b0;
    fire(7'b0010000, 1'b0, 1'b0, 32'h8000_3000, 32'h0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_in_redirect: rv=%b required 1", redirect_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({exc_valid, exc_eret, flush, redirect_valid, redirect_pc, exc_excode} !== '0) begin
      errors++;
      $display("FAIL ar_immediate: ev=%b fl=%b rv=%b rpc=%h code=%h required all 0", exc_valid, flush, redirect_valid, redirect_pc, exc_excode);
    end
    redirect_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({exc_valid, flush, redirect_valid} !== 3'b0) begin
      errors++;
      $display("FAIL ar_idle_after: ev=%b fl=%b rv=%b required 000", exc_valid, flush, redirect_valid);
    end
    fire(7'b0100000, 1'b0, 1'b0, 32'h8000_4000, 32'h0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (exc_valid !== 1'b1 || exc_excode !== 5'h0a) begin
      errors++;
      $display("FAIL ar_next_take: ev=%b code=%h required 1 0a", exc_valid, exc_excode);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_no_take();
    test_ri();
    test_ov_bd();
    test_int_priority();
    test_eret();
    test_prio_table();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
